uart_tx_feeder: RTL and testbench



---
 rtl/uart_tx_feeder.sv | 113 +++++++++++
 tb/tb_uart_tx_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter. Each byte is launched with a one-cycle
// tx_start pulse, and tx_din is held until the transmitter reports tx_done.
module uart_tx_feeder #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DBIT-1:0]   wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              tx_done,
   output logic              tx_start,
   output logic [DBIT-1:0]   tx_din,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic {L_IDLE = 1'b0, L_WAIT = 1'b1} state_t;

   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              tx_start_q, tx_start_d;
   logic [DBIT-1:0]   tx_din_q, tx_din_d;
   logic              busy_q, busy_d;
   state_t            state_q, state_d;
   logic              push, pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign tx_start = tx_start_q;
   assign tx_din   = tx_din_q;
   assign busy     = busy_q;

   // A full FIFO refuses the push even when the launcher pops in the same cycle.
   assign push = wr_en && !full;

   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_din_d   = tx_din_q;
      busy_d     = busy_q;
      pop        = 1'b0;
      case (state_q)
         L_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               tx_din_d   = mem_q[rd_ptr_q];
               tx_start_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = L_WAIT;
            end
         end
         L_WAIT: begin
            if (tx_done) begin
               busy_d  = 1'b0;
               state_d = L_IDLE;
            end
         end
         default: state_d = L_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = wr_en && full;
      count_d    = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   // Storage is left uninitialised on reset; only the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (rst_n && push)
         mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_start_q <= 1'b0;
         tx_din_q   <= '0;
         busy_q     <= 1'b0;
         state_q    <= L_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_start_q <= tx_start_d;
         tx_din_q   <= tx_din_d;
         busy_q     <= busy_d;
         state_q    <= state_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a table of directed vectors and directed corner
// sequences, then random traffic, all checked against a queue-based reference model.
module tb_uart_tx_feeder;
   localparam int DBIT   = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic             clk = 1'b0;
   logic             rst_n, wr_en, tx_done;
   logic [DBIT-1:0]  wr_data;
   logic             full, empty, overflow, tx_start, busy;
   logic [ADDR_W:0]  count;
   logic [DBIT-1:0]  tx_din;

   always #5 clk = ~clk;

   uart_tx_feeder #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .tx_done(tx_done), .tx_start(tx_start), .tx_din(tx_din), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   int launches = 0;
   logic [7:0] last_din = 8'h00;

   // Reference model: the queue holds the bytes waiting in the FIFO; m_busy means a frame is out.
   logic [7:0] m_q[$];
   logic       m_busy = 1'b0, m_start = 1'b0, m_ovf = 1'b0;
   logic [7:0] m_din = 8'h00;

   typedef struct {
      logic       rn, we;
      logic [7:0] d;
      logic       done;
      logic [4:0] e_cnt;
      logic       e_start;
      logic [7:0] e_din;
      logic       e_busy, e_ovf;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic rn, input logic we, input logic [7:0] d, input logic done);
      logic full_b;
      rst_n = rn; wr_en = we; wr_data = d; tx_done = done;
      @(posedge clk);
      #1;
      if (!rn) begin
         m_q.delete();
         m_busy = 1'b0; m_start = 1'b0; m_ovf = 1'b0; m_din = 8'h00;
      end else begin
         full_b  = (m_q.size() == DEPTH);
         m_ovf   = we && full_b;
         m_start = 1'b0;
         if (!m_busy) begin
            if (m_q.size() > 0) begin
               m_din   = m_q.pop_front();
               m_start = 1'b1;
               m_busy  = 1'b1;
            end
         end else if (done) begin
            m_busy = 1'b0;
         end
         if (we && !full_b) m_q.push_back(d);
      end
      check("count",    32'(count),    32'(m_q.size()));
      check("full",     32'(full),     32'(m_q.size() == DEPTH));
      check("empty",    32'(empty),    32'(m_q.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("tx_start", 32'(tx_start), 32'(m_start));
      check("tx_din",   32'(tx_din),   32'(m_din));
      check("busy",     32'(busy),     32'(m_busy));
      if (tx_start) begin
         launches++;
         last_din = tx_din;
         $display("launch #%0d byte %02h count %0d", launches, tx_din, count);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || !empty) && n < 2000) begin
         step(1'b1, 1'b0, 8'h00, busy && !tx_start);
         n++;
      end
      check("drain_idle", 32'({busy, empty}), 32'(2'b01));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int burst_n, last_launch, last_done, cyc, base;
      logic dn;

      rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;

      // Reset with wr_en high, single byte 0xA5, hold, tx_done, tx_done ignored in idle.
      tbl[0] = '{1'b0, 1'b1, 8'h33, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 8'h33, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hA5, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hA5, 1'b0, 1'b0};
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].rn, tbl[i].we, tbl[i].d, tbl[i].done);
         check("tbl_count", 32'(count),    32'(tbl[i].e_cnt));
         check("tbl_start", 32'(tx_start), 32'(tbl[i].e_start));
         check("tbl_din",   32'(tx_din),   32'(tbl[i].e_din));
         check("tbl_busy",  32'(busy),     32'(tbl[i].e_busy));
         check("tbl_ovf",   32'(overflow), 32'(tbl[i].e_ovf));
         $display("vector %0d: count %0d start %0b din %02h busy %0b", i, count, tx_start, tx_din, busy);
      end

      // Burst 0x01..0x05, tx_done 20 cycles after each launch.
      burst_n = 0; last_launch = 0; last_done = 0;
      for (cyc = 0; cyc < 300 && !(burst_n == 5 && !busy); cyc++) begin
         dn = (burst_n > 0) && (cyc == last_launch + 20);
         step(1'b1, cyc < 5, 8'(cyc + 1), dn);
         if (tx_start) begin
            check("burst_din", 32'(tx_din), 32'(burst_n + 1));
            if (burst_n > 0) check("burst_gap", 32'(cyc), 32'(last_done + 1));
            burst_n++;
            last_launch = cyc;
         end
         if (dn) last_done = cyc;
      end
      check("burst_frames", 32'(burst_n), 32'd5);
      check("burst_idle", 32'(busy), 32'd0);

      // Fill to full and overflow while the first frame is held open.
      for (int k = 0; k < 18; k++) begin
         step(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
         if (k == 16) begin
            check("fill_full", 32'(full), 32'd1);
            check("fill_count", 32'(count), 32'd16);
         end
         if (k == 17) begin
            check("ovf_pulse", 32'(overflow), 32'd1);
            check("ovf_count", 32'(count), 32'd16);
         end
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("ovf_clear", 32'(overflow), 32'd0);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      check("done_busy", 32'(busy), 32'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("relaunch_start", 32'(tx_start), 32'd1);
      check("relaunch_din", 32'(tx_din), 32'h41);
      check("relaunch_count", 32'(count), 32'd15);
      check("relaunch_full", 32'(full), 32'd0);
      drain();
      check("fill_last", 32'(last_din), 32'h50);

      // Push and pop on the same edge with count 3 in idle.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'(8'h51 + k), 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      check("simul_pre_count", 32'(count), 32'd3);
      check("simul_pre_busy", 32'(busy), 32'd0);
      step(1'b1, 1'b1, 8'hEE, 1'b0);
      check("simul_count", 32'(count), 32'd3);
      check("simul_din", 32'(tx_din), 32'h52);
      drain();
      check("simul_tail", 32'(last_din), 32'hEE);

      // Random traffic; pointers wrap many times through the 16-entry FIFO.
      base = launches;
      for (int i = 0; i < 800; i++)
         step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), busy && !tx_start && ($urandom_range(0, 2) == 0));
      drain();
      check("rand_frames_ge40", 32'(launches - base >= 40), 32'd1);

      // Reset in the middle of a frame with 4 bytes queued.
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 8'(8'h90 + k), 1'b0);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_count", 32'(count), 32'd4);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_din", 32'(tx_din), 32'd0);
      base = launches;
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
      check("rst_no_launch", 32'(launches - base), 32'd0);
      step(1'b1, 1'b1, 8'h77, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("post_rst_start", 32'(tx_start), 32'd1);
      check("post_rst_din", 32'(tx_din), 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
